// File: rtl/f_fetch_unit_pkg.sv
// Shared types and constants for the F-stage fetch unit.
package f_fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_VAL  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR_VAL = 32'h0000_0000;

    typedef enum logic {
        F_S_REQ  = 1'b0,
        F_S_HOLD = 1'b1
    } f_state_e;

    // Contents of the F/D pipeline register.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic        exc_adel;
    } f2d_t;

    // Instruction fetches must be word aligned.
    function automatic logic pc_misaligned(input logic [31:0] pc);
        return (pc[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/f_fetch_unit_f2d_pipe_reg.sv
// F/D pipeline register: captures the fetched instruction on a load enable.
module f_fetch_unit_f2d_pipe_reg
    import f_fetch_unit_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_VAL
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic load_i,
    input  f2d_t d_i,
    output f2d_t q_o
);

    f2d_t f2d_q;

    // Reset leaves a NOP marked invalid so D never acts on reset content.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            f2d_q.pc       <= 32'h0;
            f2d_q.instr    <= NOP_INSTR;
            f2d_q.valid    <= 1'b0;
            f2d_q.exc_adel <= 1'b0;
        end else if (load_i) begin
            f2d_q <= d_i;
        end
    end

    assign q_o = f2d_q;

endmodule

// File: rtl/f_fetch_unit.sv
// F-stage fetch unit: PC register, imem req/ack handshake and F/D register.
//
// state    | meaning
// ---------+------------------------------------------------------------
// F_S_REQ  | requesting pc from imem (or pc misaligned: no request)
// F_S_HOLD | instruction acked during a stall, parked in hold buffer
//
// pc only advances to i_npc on the edge where an instruction enters D, so
// the NPC logic always sees the PC of the instruction currently leaving F.
module f_fetch_unit
    import f_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_VAL,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_VAL
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_npc,
    input  logic        i_stall,
    output logic [31:0] o_F_pc,
    output logic        o_F_ready,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_D_pc,
    output logic [31:0] o_D_instr,
    output logic        o_D_valid,
    output logic        o_D_exc_adel
);

    f_state_e    state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic        mis;
    logic        imem_req;
    logic        f_ready;
    logic        d_load;
    f2d_t        d_next;
    f2d_t        d_q;

    assign mis = pc_misaligned(pc_q);

    // State, PC and hold buffer registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= F_S_REQ;
            pc_q         <= RESET_PC;
            hold_instr_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_instr_q <= hold_instr_d;
        end
    end

    // Next-state, handshake outputs and F/D load selection.
    // A misaligned pc is never sent to memory; it is handed to D as a NOP
    // flagged with exc_adel. An ack in F_S_HOLD is a protocol error and ignored.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        hold_instr_d    = hold_instr_q;
        imem_req        = 1'b0;
        f_ready         = 1'b0;
        d_load          = 1'b0;
        d_next.pc       = pc_q;
        d_next.instr    = NOP_INSTR;
        d_next.valid    = 1'b1;
        d_next.exc_adel = 1'b0;
        case (state_q)
            F_S_REQ: begin
                imem_req = !mis;
                f_ready  = mis | i_imem_ack;
                if (f_ready && !i_stall) begin
                    d_load          = 1'b1;
                    d_next.instr    = mis ? NOP_INSTR : i_imem_rdata;
                    d_next.exc_adel = mis;
                    pc_d            = i_npc;
                end else if (i_imem_ack && i_stall && !mis) begin
                    hold_instr_d = i_imem_rdata;
                    state_d      = F_S_HOLD;
                end
            end
            F_S_HOLD: begin
                f_ready = 1'b1;
                if (!i_stall) begin
                    d_load       = 1'b1;
                    d_next.instr = hold_instr_q;
                    pc_d         = i_npc;
                    state_d      = F_S_REQ;
                end
            end
        endcase
    end

    f_fetch_unit_f2d_pipe_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_f2d (
        .clk_i  (i_clk),
        .rst_n_i(i_rst_n),
        .load_i (d_load),
        .d_i    (d_next),
        .q_o    (d_q)
    );

    assign o_F_pc       = pc_q;
    assign o_imem_addr  = pc_q;
    assign o_imem_req   = imem_req;
    assign o_F_ready    = f_ready;
    assign o_D_pc       = d_q.pc;
    assign o_D_instr    = d_q.instr;
    assign o_D_valid    = d_q.valid;
    assign o_D_exc_adel = d_q.exc_adel;

endmodule

// File: tb/tb_f_fetch_unit.sv
// Directed bench for f_fetch_unit: vector table plus reset sequences.
module tb_f_fetch_unit;

    logic        i_clk;
    logic        i_rst_n;
    logic [31:0] i_npc;
    logic        i_stall;
    logic [31:0] o_F_pc;
    logic        o_F_ready;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack;
    logic [31:0] i_imem_rdata;
    logic [31:0] o_D_pc;
    logic [31:0] o_D_instr;
    logic        o_D_valid;
    logic        o_D_exc_adel;

    int n_cmp  = 0;
    int n_fail = 0;

    f_fetch_unit dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_npc       (i_npc),
        .i_stall     (i_stall),
        .o_F_pc      (o_F_pc),
        .o_F_ready   (o_F_ready),
        .o_imem_req  (o_imem_req),
        .o_imem_addr (o_imem_addr),
        .i_imem_ack  (i_imem_ack),
        .i_imem_rdata(i_imem_rdata),
        .o_D_pc      (o_D_pc),
        .o_D_instr   (o_D_instr),
        .o_D_valid   (o_D_valid),
        .o_D_exc_adel(o_D_exc_adel)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Memory protocol: an ack must only answer an outstanding request.
    always @(posedge i_clk) begin
        if (i_rst_n && i_imem_ack && !o_imem_req) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ack_without_req: ack=1 while req=%0b at %0t", o_imem_req, $time);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        stall;
        logic [31:0] npc;
        logic        exp_req;
        logic        exp_ready;
        logic [31:0] exp_pc;
        logic [31:0] exp_dpc;
        logic [31:0] exp_dinstr;
        logic        exp_dvalid;
        logic        exp_adel;
    } vec_t;

    localparam int NV = 15;
    localparam logic [31:0] X = 32'hA5A5_A5A5;
    localparam logic [31:0] J = 32'hDEAD_BEE0;

    vec_t        vecs[NV];
    logic [31:0] cur_pc;

    initial begin
        // zero-wait stream
        vecs[0]  = '{1'b1, 32'h3000 ^ X, 1'b0, 32'h3004, 1'b1, 1'b1, 32'h3004, 32'h3000, 32'h3000 ^ X, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 32'h3004 ^ X, 1'b0, 32'h3008, 1'b1, 1'b1, 32'h3008, 32'h3004, 32'h3004 ^ X, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 32'h3008 ^ X, 1'b0, 32'h300C, 1'b1, 1'b1, 32'h300C, 32'h3008, 32'h3008 ^ X, 1'b1, 1'b0};
        // ack under stall -> hold for two stall cycles -> release
        vecs[3]  = '{1'b1, 32'h2401_0001, 1'b1, J, 1'b1, 1'b1, 32'h300C, 32'h3008, 32'h3008 ^ X, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 32'h0, 1'b1, J, 1'b0, 1'b1, 32'h300C, 32'h3008, 32'h3008 ^ X, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 32'h0, 1'b1, J, 1'b0, 1'b1, 32'h300C, 32'h3008, 32'h3008 ^ X, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 32'h0, 1'b0, 32'h3010, 1'b0, 1'b1, 32'h3010, 32'h300C, 32'h2401_0001, 1'b1, 1'b0};
        // three-cycle latency (one waiting cycle also stalled)
        vecs[7]  = '{1'b0, 32'h0, 1'b0, J, 1'b1, 1'b0, 32'h3010, 32'h300C, 32'h2401_0001, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 32'h0, 1'b1, J, 1'b1, 1'b0, 32'h3010, 32'h300C, 32'h2401_0001, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 32'h8C08_0000, 1'b0, 32'h3014, 1'b1, 1'b1, 32'h3014, 32'h3010, 32'h8C08_0000, 1'b1, 1'b0};
        // redirect, then an unaligned target
        vecs[10] = '{1'b1, 32'h1111_1111, 1'b0, 32'h3100, 1'b1, 1'b1, 32'h3100, 32'h3014, 32'h1111_1111, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 32'h3100 ^ X, 1'b0, 32'h3102, 1'b1, 1'b1, 32'h3102, 32'h3100, 32'h3100 ^ X, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 32'hFFFF_FFFF, 1'b1, J, 1'b0, 1'b1, 32'h3102, 32'h3100, 32'h3100 ^ X, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 32'hFFFF_FFFF, 1'b0, 32'h3200, 1'b0, 1'b1, 32'h3200, 32'h3102, 32'h0, 1'b1, 1'b1};
        vecs[14] = '{1'b1, 32'h0123_4567, 1'b0, 32'h3204, 1'b1, 1'b1, 32'h3204, 32'h3200, 32'h0123_4567, 1'b1, 1'b0};

        i_rst_n      = 1'b0;
        i_npc        = 32'h0;
        i_stall      = 1'b0;
        i_imem_ack   = 1'b0;
        i_imem_rdata = 32'h0;

        // reset release with idle memory
        repeat (2) @(posedge i_clk);
        #3 i_rst_n = 1'b1;
        #1;
        chk("rst_pc",     o_F_pc,      32'h3000);
        chk("rst_req",    o_imem_req,  1);
        chk("rst_addr",   o_imem_addr, 32'h3000);
        chk("rst_dvalid", o_D_valid,   0);
        chk("rst_ready",  o_F_ready,   0);
        @(posedge i_clk);
        #1;
        chk("idle_pc",     o_F_pc,    32'h3000);
        chk("idle_dvalid", o_D_valid, 0);
        cur_pc = 32'h3000;

        for (int i = 0; i < NV; i++) begin
            i_imem_ack   = vecs[i].ack;
            i_imem_rdata = vecs[i].rdata;
            i_stall      = vecs[i].stall;
            i_npc        = vecs[i].npc;
            #1;
            chk($sformatf("v%0d_req", i),   o_imem_req, vecs[i].exp_req);
            chk($sformatf("v%0d_ready", i), o_F_ready,  vecs[i].exp_ready);
            if (vecs[i].exp_req)
                chk($sformatf("v%0d_addr", i), o_imem_addr, cur_pc);
            @(posedge i_clk);
            #1;
            i_imem_ack = 1'b0;
            chk($sformatf("v%0d_pc", i),     o_F_pc,       vecs[i].exp_pc);
            chk($sformatf("v%0d_dpc", i),    o_D_pc,       vecs[i].exp_dpc);
            chk($sformatf("v%0d_dinstr", i), o_D_instr,    vecs[i].exp_dinstr);
            chk($sformatf("v%0d_dvalid", i), o_D_valid,    vecs[i].exp_dvalid);
            chk($sformatf("v%0d_adel", i),   o_D_exc_adel, vecs[i].exp_adel);
            cur_pc = vecs[i].exp_pc;
        end

        // reset while waiting for an ack
        i_imem_ack = 1'b0;
        i_stall    = 1'b0;
        i_npc      = J;
        @(posedge i_clk);
        #1;
        chk("wait_pc", o_F_pc, 32'h3204);
        #2 i_rst_n = 1'b0;
        #1;
        chk("arst1_pc",     o_F_pc,       32'h3000);
        chk("arst1_req",    o_imem_req,   1);
        chk("arst1_dvalid", o_D_valid,    0);
        chk("arst1_dpc",    o_D_pc,       32'h0);
        chk("arst1_dinstr", o_D_instr,    32'h0);
        chk("arst1_adel",   o_D_exc_adel, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        chk("rel1_req",  o_imem_req,  1);
        chk("rel1_addr", o_imem_addr, 32'h3000);

        // reset while holding a stalled instruction
        i_imem_ack   = 1'b1;
        i_imem_rdata = 32'h2401_0002;
        i_stall      = 1'b1;
        @(posedge i_clk);
        #1;
        i_imem_ack = 1'b0;
        chk("hold_req",    o_imem_req, 0);
        chk("hold_ready",  o_F_ready,  1);
        chk("hold_dvalid", o_D_valid,  0);
        #2 i_rst_n = 1'b0;
        #1;
        chk("arst2_req",    o_imem_req, 1);
        chk("arst2_ready",  o_F_ready,  0);
        chk("arst2_pc",     o_F_pc,     32'h3000);
        chk("arst2_dvalid", o_D_valid,  0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_stall = 1'b0;
        @(posedge i_clk);
        #1;
        chk("rel2_req",    o_imem_req,  1);
        chk("rel2_addr",   o_imem_addr, 32'h3000);
        chk("rel2_dvalid", o_D_valid,   0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
